// File: rtl/branch_pdt.sv
// Direct-mapped branch predictor table.
// Each entry holds valid, tag, target and a 2-bit saturating counter.
// Lookup is combinational from pc. Updates from the ID stage take effect
// at the next clock edge.
module branch_pdt #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        branch_or_not,
    output logic [31:0] pdt_pc
);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];
    logic [1:0]         ctr_mem    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    // Word-aligned fetch: the byte offset never affects index or tag.
    logic unused_bits;
    assign unused_bits = ^{pc[1:0], upd_pc[1:0]};

    assign lk_idx = pc[IDX_W+1:2];
    assign lk_tag = pc[31:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];
    assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);

    // Zero-latency prediction. It reads the current contents, so an update
    // in the same cycle is not visible until after the edge.
    always_comb begin
        branch_or_not = 1'b0;
        pdt_pc        = 32'h0;
        if (ce && valid[lk_idx] && (tag_mem[lk_idx] == lk_tag) && ctr_mem[lk_idx][1]) begin
            branch_or_not = 1'b1;
            pdt_pc        = target_mem[lk_idx];
        end
    end

    // Table update. Reset has priority over an update in the same cycle.
    // Tags and targets are not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                ctr_mem[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (ctr_mem[up_idx] != 2'b11)
                        ctr_mem[up_idx] <= ctr_mem[up_idx] + 2'b01;
                    target_mem[up_idx] <= upd_target;
                end else if (ctr_mem[up_idx] != 2'b00) begin
                    ctr_mem[up_idx] <= ctr_mem[up_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                // A taken branch that misses replaces whatever aliased here.
                valid[up_idx]      <= 1'b1;
                tag_mem[up_idx]    <= up_tag;
                target_mem[up_idx] <= upd_target;
                ctr_mem[up_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_pdt.sv
// Scoreboard bench for branch_pdt. The driver computes the expected
// prediction from a behavioural table and queues it. The monitor checks
// the DUT outputs on the falling edge.
module tb_branch_pdt;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [31:0] pc = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        branch_or_not;
    logic [31:0] pdt_pc;

    branch_pdt #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .ce(ce), .pc(pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target),
        .branch_or_not(branch_or_not), .pdt_pc(pdt_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        bon;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   drv_done = 1'b0;

    // Reference table. Entries are keyed by word address modulo the table size.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];

    function automatic int m_index(logic [31:0] a);
        return int'((a / 4) % ENTRIES);
    endfunction

    function automatic int unsigned m_tagof(logic [31:0] a);
        return a / (4 * ENTRIES);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    // One clock cycle. The inputs are applied and the expected outputs for
    // this cycle are queued. The model then advances to its state after the edge.
    task automatic cyc(input string name, input logic c, input logic [31:0] p,
                       input logic uv, input logic [31:0] up, input logic ut,
                       input logic [31:0] utg, input logic r);
        exp_t e;
        int   i;
        int   j;
        bit   hit;
        @(posedge clk);
        #1;
        rst = r; ce = c; pc = p;
        upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg;
        i = m_index(p);
        e.name = name;
        e.bon  = c && m_valid[i] && m_tag[i] == m_tagof(p) && m_ctr[i] >= 2;
        e.tgt  = e.bon ? m_tgt[i] : 32'h0;
        exp_q.push_back(e);
        if (r) begin
            m_reset();
        end else if (uv) begin
            j   = m_index(up);
            hit = m_valid[j] && m_tag[j] == m_tagof(up);
            if (hit && ut) begin
                m_ctr[j] = (m_ctr[j] < 3) ? m_ctr[j] + 1 : 3;
                m_tgt[j] = utg;
            end else if (hit) begin
                m_ctr[j] = (m_ctr[j] > 0) ? m_ctr[j] - 1 : 0;
            end else if (ut) begin
                m_valid[j] = 1'b1;
                m_tag[j]   = m_tagof(up);
                m_tgt[j]   = utg;
                m_ctr[j]   = 2;
            end
        end
    endtask

    task automatic look(input string name, input logic [31:0] p);
        cyc(name, 1'b1, p, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic upd(input string name, input logic [31:0] p, input logic ut,
                       input logic [31:0] utg);
        cyc(name, 1'b1, p, 1'b1, p, ut, utg, 1'b0);
    endtask

    // Monitor: compare the DUT outputs against the queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (branch_or_not === e.bon) passed++;
                else $display("FAIL %s branch_or_not: got %b want %b", e.name, branch_or_not, e.bon);
                checks++;
                if (pdt_pc === e.tgt) passed++;
                else $display("FAIL %s pdt_pc: got %h want %h", e.name, pdt_pc, e.tgt);
            end
        end
    end

    // Driver: directed scenarios first, then random traffic.
    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        look("reset_0x40", 32'h40);
        look("reset_0x200", 32'h200);
        // First taken update. The lookup in the same cycle sees the old contents.
        upd("alloc_same_cycle", 32'h40, 1'b1, 32'h100);
        look("hit_0x40", 32'h40);
        look("alias_0x80", 32'h80);
        cyc("ce_off", 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        upd("nt_to_01", 32'h40, 1'b0, 32'h0);
        look("ctr01", 32'h40);
        upd("t_to_10", 32'h40, 1'b1, 32'h100);
        upd("t_to_11", 32'h40, 1'b1, 32'h100);
        look("ctr11", 32'h40);
        upd("nt_to_10", 32'h40, 1'b0, 32'h0);
        look("ctr10", 32'h40);
        upd("nt_to_01b", 32'h40, 1'b0, 32'h0);
        look("ctr01b", 32'h40);
        upd("nt_to_00", 32'h40, 1'b0, 32'h0);
        look("ctr00", 32'h40);
        upd("nt_sat_00", 32'h40, 1'b0, 32'h0);
        look("ctr00_sat", 32'h40);
        upd("t_sat_up1", 32'h40, 1'b1, 32'h104);
        upd("t_sat_up2", 32'h40, 1'b1, 32'h108);
        upd("t_sat_up3", 32'h40, 1'b1, 32'h10c);
        upd("t_sat_up4", 32'h40, 1'b1, 32'h110);
        look("ctr11_sat_newtgt", 32'h40);
        upd("nt_no_alloc", 32'h200, 1'b0, 32'h0);
        look("no_alloc_0x200", 32'h200);
        // An update is applied even when ce is low.
        cyc("ce0_update", 1'b0, 32'h0, 1'b1, 32'h84, 1'b1, 32'h300, 1'b0);
        look("ce0_upd_hit", 32'h86);
        upd("alias_replace", 32'h80, 1'b1, 32'h400);
        look("replaced_0x80", 32'h80);
        look("evicted_0x40", 32'h40);
        upd("realloc_0x40", 32'h40, 1'b1, 32'h100);
        cyc("rst_with_upd", 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h500, 1'b1);
        look("after_rst_0x40", 32'h40);
        look("after_rst_0x84", 32'h84);
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [31:0] p;
            a = $urandom_range(0, 1023);
            p = $urandom_range(0, 1023);
            cyc("rand", ($urandom_range(0, 7) != 0), p,
                ($urandom_range(0, 2) != 0), a, $urandom_range(0, 1) == 1,
                $urandom, ($urandom_range(0, 199) == 0));
        end
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        rst = 1'b0;
        drv_done = 1'b1;
    end

    // Finish once every queued expectation has been checked, within a cycle budget.
    initial begin
        int budget;
        budget = 5000;
        while (!(drv_done && exp_q.size() == 0) && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            $display("FAIL timeout: got %0d pending want 0", exp_q.size());
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/branch_pdt.md
BRANCH_PDT -- requirements
Module: branch_pdt

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, giving the number of direct-mapped table entries (power of two, 4..64).
REQ-002 SHALL have parameter IDX_W, default 4, equal to log2(ENTRIES).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ce  input  1  fetch chip enable from the PC stage; 0 suppresses prediction.
REQ-006 pc  input  32  current fetch address from the PC stage.
REQ-007 upd_valid  input  1  resolved-branch update strobe from ID, one cycle per branch.
REQ-008 upd_pc  input  32  address of the resolved branch.
REQ-009 upd_taken  input  1  actual direction of the resolved branch.
REQ-010 upd_target  input  32  actual target of the resolved branch; meaningful only when upd_taken=1.
REQ-011 branch_or_not  output  1  predict-taken flag to the PC stage.
REQ-012 pdt_pc  output  32  predicted target to the PC stage.

Function
REQ-013 SHALL hold ENTRIES entries, each with: valid (1b), tag (pc[31:IDX_W+2]), target (32b), ctr (2b saturating).
REQ-014 Index SHALL be addr[IDX_W+1:2]; tag SHALL be addr[31:IDX_W+2]; addr[1:0] SHALL be ignored.
REQ-015 Lookup SHALL be combinational from pc, with zero-cycle latency, so the PC stage consumes it on the same edge.
REQ-016 Hit SHALL be defined as valid AND stored tag equal to pc tag.
REQ-017 branch_or_not SHALL be 1 iff ce=1 AND hit AND ctr[1]=1; otherwise 0.
REQ-018 pdt_pc SHALL equal the stored target when branch_or_not=1, else 32'h0.
REQ-019 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-020 Update with upd_valid=1 and the indexed entry hitting on upd_pc: taken → ctr+1 saturating at 11, and target <= upd_target; not-taken → ctr-1 saturating at 00, target unchanged.
REQ-021 Update with upd_valid=1, miss, upd_taken=1: SHALL allocate/overwrite the entry with valid=1, tag=upd_pc tag, target=upd_target, ctr=10.
REQ-022 Update with upd_valid=1, miss, upd_taken=0: SHALL leave the table unchanged (no allocation).
REQ-023 upd_valid=0: SHALL leave the table unchanged.
REQ-024 Updates SHALL take effect at the next posedge; a lookup in the same cycle as an update to the same index SHALL see pre-update contents.
REQ-025 ce=0 SHALL NOT block updates.
REQ-026 Aliasing (same index, different tag) SHALL be resolved only by REQ-021 replacement; no associativity.

Reset
REQ-027 On posedge clk with rst=1, all valid bits SHALL clear to 0 and all ctr SHALL set to 01; tags and targets are don't-care.
REQ-028 With rst=1, updates SHALL be ignored that cycle (reset wins over a simultaneous upd_valid).
REQ-029 After reset, branch_or_not=0 and pdt_pc=32'h0 for every pc until a taken update allocates an entry.

Verification
REQ-030 Reset, then ce=1, pc=0x40 → branch_or_not=0, pdt_pc=0.
REQ-031 Update pc=0x40 taken target=0x100, then pc=0x40 → branch_or_not=1, pdt_pc=0x100; pc=0x80 (same index, tag differs) → 0.
REQ-032 From REQ-031 state: one not-taken update for 0x40 → ctr=01, prediction 0; two taken updates → ctr=11; three not-taken → ctr 10, 01, 00, prediction 1, 0, 0; a further not-taken stays at 00.
REQ-033 Not-taken update for unallocated 0x200 → no entry; pc=0x200 predicts 0.
REQ-034 pc=0x40 lookup in the same cycle as the first taken update to 0x40 → branch_or_not=0 that cycle, 1 the next cycle; with ce=0 → 0 regardless of table.
REQ-035 With entry 0x40 valid, assert rst together with upd_valid (0x40 taken) → after the edge, pc=0x40 predicts 0.
